// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Request/result bundle for the bit-serial adder/subtractor
//               controller (start/ready/done handshake, operands, result).
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    // Requesting unit side
    modport master (
        output start, sub, a, b,
        input  ready, busy, done, sum, carry
    );

    // Controller side
    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, sum, carry
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial WIDTH-bit adder/subtractor. A single full-adder
//               cell (two half adders plus an OR) is reused LSB-first, one
//               bit per clock, with the running carry held in a flip-flop.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    serial_adder_ctrl_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_cff;
    logic [WIDTH-2:0] r_sh;      // partial result; the newest bit joins at the top
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic             w_s1;
    logic             w_c1;
    logic             w_s;
    logic             w_c2;
    logic             w_cout;
    logic [WIDTH-1:0] w_shift;

    // Shared full-adder cell on the current LSB pair and the carry flip-flop
    always_comb begin
        w_s1    = r_opa[0] ^ r_opb[0];
        w_c1    = r_opa[0] & r_opb[0];
        w_s     = w_s1 ^ r_cff;
        w_c2    = w_s1 & r_cff;
        w_cout  = w_c1 | w_c2;
        w_shift = {w_s, r_sh};
    end

    // Sequencer: capture operands, step one bit per edge, publish result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_cff   <= 1'b0;
            r_sh    <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1: the +1 enters as the initial carry
                        r_opa   <= bus.a;
                        r_opb   <= bus.sub ? ~bus.b : bus.b;
                        r_cff   <= bus.sub;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_opa <= {1'b0, r_opa[WIDTH-1:1]};
                    r_opb <= {1'b0, r_opb[WIDTH-1:1]};
                    r_cff <= w_cout;
                    r_sh  <= w_shift[WIDTH-1:1];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        // Result registers change only here, so they stay stable during RUN
                        r_sum   <= w_shift;
                        r_carry <= w_cout;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.sum   = r_sum;
    assign bus.carry = r_carry;

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial WIDTH-bit adder/subtractor controller. One 1-bit full-adder cell, built from two half-adder stages plus an OR, is reused once per bit. A small FSM sequences the cell LSB-first and holds the running carry in a flip-flop. The block sits between a requesting unit and the shared adder cell, trading latency for area. It uses a start/ready/done handshake.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits, ≥ 2.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only when ready=1.
- sub  in  1  0 = a+b, 1 = a−b; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- ready  out  1  high in IDLE; the block accepts start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; sum and carry are valid.
- sum  out  WIDTH  result register.
- carry  out  1  add: carry-out. Sub: 1 = no borrow (a ≥ b unsigned).

## Operation
- FSM states are IDLE, RUN and DONE. The state register, the bit counter, the operand shift registers, the carry flip-flop, sum and carry are all clocked registers.
- IDLE: ready=1, busy=0.
  - start=1 at an edge captures a into opA and (sub ? ~b : b) into opB.
  - The same edge sets carry FF = sub, clears the bit counter and moves to RUN.
  - start=0: stay in IDLE.
- RUN: each edge processes bit 0 of opA/opB with the cell:
  - s1 = a0^b0, c1 = a0&b0
  - s = s1^cff, c2 = s1&cff
  - cff ← c1|c2
  - s shifts into the MSB of the sum shift register. opA and opB shift right. The counter increments.
  - On the edge that processes bit WIDTH−1: sum ← final shift value, carry ← final cff, state → DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- sum and carry hold their value until the next operation completes. They do not change during RUN.
- start, a, b and sub are ignored outside IDLE. Operands are isolated after capture.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement via inverted b with carry-in 1.
- Reset (rst=1 at any edge, any state, including mid-RUN):
  - state → IDLE; counter, operand registers and cff cleared.
  - sum ← 0, carry ← 0.
  - No done pulse is issued for the aborted operation.
  - Reset has priority over start.

## Timing
- Reset values, valid after the first reset edge: ready=1, busy=0, done=0, sum=0, carry=0.
- Edge E0 samples start. RUN is active from E0 through EW, which processes bits 0..WIDTH−1 at edges E1..EW.
- done is high in the cycle after EW. Latency is WIDTH cycles from the sampling edge to done.
- ready is high again after edge EW+1. The earliest next start sample is edge EW+2, giving one operation per WIDTH+2 cycles.
- busy is high for exactly WIDTH cycles per operation.
- ready, busy and done are mutually exclusive and decoded from the state only.
- Holding start high continuously yields back-to-back operations at WIDTH+2 cycle spacing, each with its own single-cycle done.

## Test plan
1. Reset mid-RUN: start 8'h3C+8'h05, then rst high for 1 cycle at bit 4. Next cycle: ready=1, busy=0, sum=0, carry=0. No done within 20 cycles.
2. WIDTH=8 add: a=8'h3C, b=8'h05, sub=0. Required: done exactly 8 cycles after the start edge, sum=8'h41, carry=0, busy high 8 cycles.
3. Overflow: 8'hFF+8'h01 gives sum=8'h00, carry=1. 8'hFF+8'hFF gives sum=8'hFE, carry=1. 8'h00+8'h00 gives sum=8'h00, carry=0.
4. Subtract: 8'h07−8'h05 gives sum=8'h02, carry=1. 8'h05−8'h07 gives sum=8'hFE, carry=0. 8'h80−8'h80 gives sum=8'h00, carry=1.
5. Isolation: start 8'h10+8'h20, then during RUN pulse start with sub=1 and change a/b to 8'hAA/8'h55. Required: sum=8'h30, carry=0, only one done pulse.
6. Back-to-back: start held high with a stream of operand pairs. Required: a new operation is accepted every 10 cycles, and each done is exactly one cycle wide and carries the correct result.
